sram_array: RTL
===============

# sram_array

Parametrised single-port synchronous SRAM built as the multi-word successor to the single-bit latch cell. It stores `DEPTH` words of `DATA_W` bits and keeps the cell's `select`/`rdwrt` command semantics. It adds per-bit write masking, a registered read with a valid strobe, and a hardware clear sweep after reset. It sits between a bus/controller and any logic needing small local storage.

## Interface
- `DATA_W`, default 8: word width in bits (≥1).
- `ADDR_W`, default 4: address width; `DEPTH = 2**ADDR_W` words.
- `clk`  in  1: sole clock; all state updates on rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `select`  in  1: command strobe; one command per cycle when high.
- `rdwrt`  in  1: 1 = read, 0 = write (sampled only with `select`).
- `addr`  in  ADDR_W: word address.
- `in`  in  DATA_W: write data.
- `wmask`  in  DATA_W: per-bit write enable; 1 = bit written.
- `out`  out  DATA_W: registered read data.
- `valid`  out  1: one-cycle pulse, `out` holds fresh read data.
- `busy`  out  1: high while clear sweep runs; commands ignored.

## Operation
- States: INIT (clear sweep) and IDLE.
- Reset asserted (async):
  - `out`=0, `valid`=0, `busy`=1.
  - Sweep counter = 0; state = INIT.
  - Array contents are not reset directly.
- INIT:
  - Each cycle writes 0 to `mem[counter]` (full word, mask ignored) and increments the counter.
  - After writing address `DEPTH-1`, next state is IDLE.
  - `busy`=0 from the first IDLE cycle.
  - `select` is ignored throughout: no write, no `valid`, `out` unchanged.
- IDLE, `select`=1, `rdwrt`=0 (write):
  - `mem[addr] <= (mem[addr] & ~wmask) | (in & wmask)`.
  - `out` unchanged; `valid`=0.
- IDLE, `select`=1, `rdwrt`=1 (read):
  - `out <= mem[addr]`; `valid <= 1` for exactly one cycle.
- IDLE, `select`=0: no array change; `valid <= 0`; `out` holds its last value.
- `wmask`=0 write: legal no-op; no state changes.
- Single port: one command per cycle, so read-during-write cannot occur.
- Write then read of the same address on the next cycle returns the new data (array updated at the write edge).
- Address range: `addr` spans exactly `DEPTH`, so there is no out-of-range case. The sweep counter is `ADDR_W+1` bits, or uses a terminal flag, so it does not wrap early.
- Reset mid-sweep or mid-read: state, counter, `out` and `valid` return to reset values immediately (async). The sweep restarts from address 0 after `rst_n` rises. A read in flight produces no `valid`.

## Timing
- Read latency: 1 cycle. Command sampled at edge N; `out`/`valid` updated at edge N; visible during cycle N+1.
- Back-to-back reads: `valid` stays high on consecutive cycles, with new `out` each cycle.
- Write: takes effect at the sampling edge; no output response.
- Sweep duration:
  - First active edge after `rst_n` rises clears address 0.
  - `busy` falls after exactly `DEPTH` edges.
  - The first accepted command is at edge `DEPTH+1`.
- `busy` and `valid` are registered outputs, with no combinational path from inputs.

## Test plan
- Reset release, `ADDR_W`=4 -> `busy`=1 for 16 edges, then 0. Read of every address returns 0x00 with `valid` pulse.
- Write 0xA5 to addr 3 (`wmask`=0xFF), then read addr 3 next cycle -> `out`=0xA5, `valid`=1 for one cycle. Addr 4 still reads 0x00.
- Addr 3 = 0xA5; write `in`=0x0F, `wmask`=0x3C -> read returns 0x8D. A `wmask`=0x00 write leaves 0x8D.
- Reads of addrs 1, 2, 3 on consecutive cycles after distinct writes -> `valid` high 3 consecutive cycles, each `out` correct. Then `select`=0 -> `valid`=0 and `out` holds last value.
- `select`=1 write of 0xFF to addr 0 during INIT (edge 5) -> ignored; after sweep, addr 0 reads 0x00. No `valid` during `busy`.
- Issue a read, assert `rst_n`=0 before the next edge -> `out`=0, `valid`=0, `busy`=1 immediately. After release, full 16-cycle sweep reruns; prior data reads 0x00.

Source files
------------

// File: rtl/sram_array.sv
// Single-port synchronous SRAM with per-bit write mask, registered read + valid strobe,
// and a hardware clear sweep that zeroes every word after reset before commands are accepted.
module sram_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              select_i,
    input  logic              rdwrt_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] in_i,
    input  logic [DATA_W-1:0] wmask_i,
    output logic [DATA_W-1:0] out_o,
    output logic              valid_o,
    output logic              busy_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        INIT,
        IDLE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic                memWe;
    logic [ADDR_W-1:0]   memAddr;
    logic [DATA_W-1:0]   memWdata;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;
        memWe    = 1'b0;
        memAddr  = addr_i;
        memWdata = (mem[addr_i] & ~wmask_i) | (in_i & wmask_i);

        case (state_q)
            INIT: begin
                // Sweep owns the array: full-word zero writes, commands ignored.
                memWe    = 1'b1;
                memAddr  = cnt_q[ADDR_W-1:0];
                memWdata = '0;
                cnt_d    = cnt_q + (ADDR_W+1)'(1);
                if (cnt_q == (ADDR_W+1)'(DEPTH - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            IDLE: begin
                if (select_i) begin
                    if (rdwrt_i) begin
                        out_d   = mem[addr_i];
                        valid_d = 1'b1;
                    end else begin
                        memWe = 1'b1;
                    end
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    // Storage has no reset; the post-reset sweep is what gives it defined contents.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[memAddr] <= memWdata;
        end
    end

    assign out_o   = out_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;

endmodule
